// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg -- shared constants and types for the sequential multiplier.
//
// Contents:
//   WIDTH_DEF : default operand width
//   CNT_W     : step-counter width for the default operand width
//   state_t   : controller FSM states (IDLE, BUSY, DONE)
//   cnt_bits  : step-counter width for an arbitrary operand width
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W     = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // A 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step -- one shift-add step of the multiplier (purely combinational).
//
// Ports:
//   acc      in  2*WIDTH  running partial product
//   addend   in  2*WIDTH  multiplicand already shifted to this step's weight
//   mbit     in  1        multiplier bit for this step
//   acc_nxt  out 2*WIDTH  partial product after this step
// ---------------------------------------------------------------------------
module mult_step
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] addend,
   input  logic               mbit,
   output logic [2*WIDTH-1:0] acc_nxt
);

   always_comb begin
      acc_nxt = acc;
      if (mbit) acc_nxt = acc + addend;
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl -- sequential shift-add multiplier owning the HI/LO pair.
//
// A multiply takes WIDTH BUSY cycles plus one DONE cycle; HI/LO are committed
// on the DONE->IDLE edge. MTHI/MTLO writes are accepted only while IDLE.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   start         in   begin a multiply (ignored unless IDLE)
//   is_signed     in   1 = signed multiply (only with MULT_SIGNED_EN)
//   multiplier    in   WIDTH  first operand (rs)
//   multiplicand  in   WIDTH  second operand (rt)
//   flush         in   abandon an in-flight multiply, HI/LO untouched
//   hi_we, lo_we  in   MTHI / MTLO write strobes
//   wdata         in   WIDTH  MTHI / MTLO data
//   rd_req        in   MFHI / MFLO issued this cycle
//   busy          out  multiply in progress (BUSY or DONE)
//   done          out  one-cycle pulse in the commit cycle
//   stall         out  busy & rd_req
//   hi, lo        out  WIDTH  architectural HI / LO
//
// Build option: define MULT_SIGNED_EN to honour is_signed. Signed operands
// are reduced to magnitudes at launch and the product is negated at commit
// when the signs differ, so latency is the same in both builds.
// ---------------------------------------------------------------------------
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] multiplier,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_req,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW   = cnt_bits(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t state_q, state_nxt;

   logic               launch;    // accept start this cycle
   logic               step_en;   // perform one shift-add step
   logic               commit;    // write the product to HI/LO
   logic               wr_ok;     // MTHI/MTLO allowed this cycle

   logic [WIDTH-1:0]   mplier_q;  // shifts right; bit 0 is the current step
   logic [2*WIDTH-1:0] mcand_q;   // shifts left; multiplicand << step
   logic [2*WIDTH-1:0] acc_q, acc_nxt;
   logic [CW-1:0]      cnt_q;
   logic               neg_q;     // product must be negated at commit
   logic [2*WIDTH-1:0] product;

   logic [WIDTH-1:0]   hi_q, lo_q;

   // ---------------- operand conditioning ----------------
   logic [WIDTH-1:0]   op_a, op_b;
   logic               neg_in;

`ifdef MULT_SIGNED_EN
   always_comb begin
      neg_in = is_signed & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
      op_a   = multiplier;
      op_b   = multiplicand;
      if (is_signed && multiplier[WIDTH-1])   op_a = ~multiplier + 1'b1;
      if (is_signed && multiplicand[WIDTH-1]) op_b = ~multiplicand + 1'b1;
   end
`else
   // is_signed has no effect in the unsigned-only build.
   logic unused_is_signed;
   assign unused_is_signed = is_signed;
   assign neg_in = 1'b0;
   assign op_a   = multiplier;
   assign op_b   = multiplicand;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE:    if (start && !flush) state_nxt = BUSY;
         BUSY: begin
            if (flush)              state_nxt = IDLE;
            else if (cnt_q == LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy    = (state_q != IDLE);
      // A flush in the DONE cycle cancels the commit, so no pulse either.
      done    = (state_q == DONE) && !flush;
      stall   = busy && rd_req;
      launch  = (state_q == IDLE) && start && !flush;
      step_en = (state_q == BUSY) && !flush;
      commit  = done;
      // Any start request in IDLE drops a simultaneous MTHI/MTLO.
      wr_ok   = (state_q == IDLE) && !start;
   end

   // ---------------- shift-add datapath ----------------
   mult_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc_q),
      .addend  (mcand_q),
      .mbit    (mplier_q[0]),
      .acc_nxt (acc_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mplier_q <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else if (launch) begin
         mplier_q <= op_a;
         mcand_q  <= {{WIDTH{1'b0}}, op_b};
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= neg_in;
      end else if (step_en) begin
         acc_q    <= acc_nxt;
         mplier_q <= mplier_q >> 1;
         mcand_q  <= mcand_q << 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

   assign product = neg_q ? (~acc_q + 1'b1) : acc_q;

   // ---------------- architectural HI / LO ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         hi_q <= product[2*WIDTH-1:WIDTH];
         lo_q <= product[WIDTH-1:0];
      end else if (wr_ok) begin
         if (hi_we) hi_q <= wdata;
         if (lo_we) lo_q <= wdata;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  request a new multiply for one cycle.
REQ-005 SHALL have port is_signed  input  1  multiply type: 1 = MULT, 0 = MULTU.
REQ-006 SHALL have port multiplier  input  WIDTH  first operand (rs).
REQ-007 SHALL have port multiplicand  input  WIDTH  second operand (rt).
REQ-008 SHALL have port flush  input  1  cancel any in-flight multiply.
REQ-009 SHALL have port hi_we / lo_we  input  1  MTHI / MTLO write strobes.
REQ-010 SHALL have port wdata  input  WIDTH  MTHI / MTLO write data.
REQ-011 SHALL have port rd_req  input  1  pipeline is issuing MFHI / MFLO this cycle.
REQ-012 SHALL have port busy  output  1  multiply in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when HI/LO have been updated by a multiply.
REQ-014 SHALL have port stall  output  1  pipeline stall request.
REQ-015 SHALL have ports hi / lo  output  WIDTH  architectural HI (product upper half) and LO (product lower half).

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 In IDLE with start=1, SHALL latch the operands, clear the step counter, clear the accumulator, and go to BUSY.
REQ-018 In BUSY, SHALL perform one shift-add step per cycle; step i SHALL add multiplicand<<i to the 2*WIDTH-bit accumulator when multiplier bit i is 1.
REQ-019 After WIDTH BUSY cycles (counter = WIDTH-1), SHALL go to DONE.
REQ-020 In DONE, SHALL write HI = acc[2W-1:W] and LO = acc[W-1:0], assert done, and return to IDLE.
REQ-021 SHALL have fixed latency: start sampled at edge N gives done=1 during cycle N+WIDTH+1; HI/LO are valid from edge N+WIDTH+2.
REQ-022 busy SHALL be 1 in BUSY and DONE, and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored; no queueing.
REQ-024 stall SHALL equal busy AND rd_req; hi/lo SHALL show the old values until DONE commits.
REQ-025 hi_we/lo_we SHALL write only in IDLE; when busy they SHALL be ignored.
REQ-026 start and hi_we/lo_we in the same IDLE cycle: start SHALL win and the write SHALL be dropped.
REQ-027 flush in BUSY or DONE SHALL return the FSM to IDLE next cycle with HI/LO unchanged and done=0.
REQ-028 flush and start together in IDLE: flush SHALL win and no operation SHALL start.
REQ-029 Product SHALL be the full 2*WIDTH bits with no truncation; unsigned 0xFFFFFFFF*0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.

Reset
REQ-030 With rst_n=0 at a clk edge, SHALL set the FSM to IDLE and set counter, accumulator, HI, LO, busy, done and stall to 0.
REQ-031 Reset during BUSY SHALL abandon the operation without updating HI/LO except by the clear to 0.

Configuration
REQ-032 With macro MULT_SIGNED_EN defined and is_signed=1, SHALL latch operand magnitudes and negate the 2W-bit product in DONE when the operand signs differ.
REQ-033 Without MULT_SIGNED_EN, SHALL ignore is_signed and treat all operands as unsigned; latency SHALL be unchanged in both builds.

Structure
REQ-034 Package mult_pkg SHALL hold the WIDTH default constant, the FSM state enum (IDLE, BUSY, DONE), and the counter-width constant clog2(WIDTH).
REQ-035 Shift-add step logic SHALL be sub-module mult_step: combinational, taking accumulator, shifted multiplicand and multiplier bit, and giving the next accumulator.

Verification
REQ-036 Unsigned 0x80000000 * 0x00000002 -> done at cycle 33 after start; HI=0x00000001, LO=0x00000000.
REQ-037 Signed build, is_signed=1, 0xFFFFFFFF * 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; unsigned build, same stimulus -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-038 Second start 5 cycles after the first -> ignored; exactly one done pulse; HI/LO hold the first result.
REQ-039 rd_req held from start to completion -> stall=1 through the DONE cycle, 0 the cycle after; hi/lo keep the old value until the commit edge.
REQ-040 rst_n=0 at BUSY step 10 -> next cycle IDLE, HI=LO=0, busy=0; flush at step 10 -> IDLE, HI/LO keep prior values, no done.
REQ-041 MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle; MTLO during BUSY -> lo unchanged.
